// File: rtl/unipolar_rz_pkg.sv
// unipolar_rz_pkg
// Shared definitions for the unipolar return-to-zero LED line transmitter and
// receiver: the time-to-cycle conversion used to derive counter limits from
// physical timing parameters, and the receiver state encoding.
package unipolar_rz_pkg;

    // Receiver states: SYNC waits for a reset gap to establish word
    // alignment, LOW waits for the next pulse, HIGH measures a pulse.
    typedef enum logic [1:0] {
        SYNC,
        LOW,
        HIGH
    } rx_state_t;

    // Converts a duration in seconds to a whole number of clock cycles,
    // rounded to nearest.
    function automatic int time_to_cycles(real seconds, real clock_rate);
        return $rtoi(seconds * clock_rate + 0.5);
    endfunction

endpackage

// File: rtl/rz_line_sync.sv
// rz_line_sync
// Two-flop synchronizer for the asynchronous serial line, followed by a
// history flop that provides single-cycle rise/fall strobes on the
// synchronized level.
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high reset
//   line_in - raw line, asynchronous to clock
//   ls      - synchronized line level
//   rise    - high for one cycle on the first cycle ls is high
//   fall    - high for one cycle on the first cycle ls is low
module rz_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic ls,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ls   = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/unipolar_rz_rx.sv
// unipolar_rz_rx
// Receiver/decoder for the single-wire unipolar return-to-zero LED protocol
// (SK6805/WS2812 class). Each high pulse is classified as a 0 or 1 by its
// width, bits are assembled LSB first into DATA_WIDTH-bit words, and a long
// low gap marks the end of a frame.
// Ports:
//   clock     - system clock
//   reset     - synchronous, active-high reset
//   line      - raw serial line, asynchronous to clock
//   data      - last complete word, bit 0 = first bit received
//   valid     - one-cycle pulse when data is updated
//   frame_end - one-cycle pulse when the reset gap is detected
//   error     - one-cycle pulse on a timing violation or partial word
//   line_out  - forwarded line (constant 0 unless forwarding is built)
// Configuration:
//   UNIPOLAR_RZ_RX_FORWARD_EN - when defined, every word after the first of a
//   frame is regenerated on line_out, one cycle behind the synchronized line.
module unipolar_rz_rx #(
    parameter int  DATA_WIDTH     = 24,
    parameter real CLOCK_RATE     = 100e6,
    parameter real ZERO_HIGH_TIME = 0.3e-6,
    parameter real ONE_HIGH_TIME  = 0.6e-6,
    parameter real MIN_HIGH_TIME  = 0.1e-6,
    parameter real MAX_HIGH_TIME  = 1.0e-6,
    parameter real RESET_TIME     = 50e-6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_end,
    output logic                  error,
    output logic                  line_out
);

    import unipolar_rz_pkg::*;

    localparam int THRESHOLD_CYCLES = time_to_cycles((ZERO_HIGH_TIME + ONE_HIGH_TIME) / 2.0, CLOCK_RATE);
    localparam int MIN_CYCLES       = time_to_cycles(MIN_HIGH_TIME, CLOCK_RATE);
    localparam int MAX_CYCLES       = time_to_cycles(MAX_HIGH_TIME, CLOCK_RATE);
    localparam int RESET_CYCLES     = time_to_cycles(RESET_TIME, CLOCK_RATE);
    localparam int CW               = $clog2(RESET_CYCLES + 1);
    localparam int BW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] THRESH_CNT   = CW'(THRESHOLD_CYCLES);
    localparam logic [CW-1:0] MIN_CNT      = CW'(MIN_CYCLES);
    localparam logic [CW-1:0] MAX_CNT      = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] RESET_CNT    = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RESET_CNT_M1 = CW'(RESET_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_WIDTH - 1);

    logic ls, ls_rise, ls_fall;

    rz_line_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .line_in (line),
        .ls      (ls),
        .rise    (ls_rise),
        .fall    (ls_fall)
    );

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_end_q, frame_end_d;
    logic                  error_q, error_d;
    logic                  bit_val;
    logic [DATA_WIDTH-1:0] shifted;

    // The counter restarts at 1 on an edge so that, on the cycle of the next
    // edge, it equals the number of cycles the previous level lasted.
    // Limits are detected one count early so each event is registered on the
    // cycle the count actually reaches its limit, and the saturated value
    // never fires them again.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_end_d = 1'b0;
        error_d     = 1'b0;
        bit_val     = (cnt_q >= THRESH_CNT);
        shifted     = {bit_val, shift_q[DATA_WIDTH-1:1]};

        if (ls_rise || ls_fall) begin
            cnt_d = CW'(1);
        end else if (cnt_q != RESET_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            SYNC: begin
                bit_cnt_d = '0;
                if (!ls && !ls_fall && cnt_q >= RESET_CNT_M1) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (ls_rise) begin
                    state_d = HIGH;
                end else if (cnt_q == RESET_CNT_M1) begin
                    frame_end_d = 1'b1;
                    error_d     = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                end
            end
            HIGH: begin
                if (ls_fall) begin
                    if (cnt_q < MIN_CNT) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = SYNC;
                    end else begin
                        shift_d = shifted;
                        state_d = LOW;
                        if (bit_cnt_q == LAST_BIT) begin
                            data_d    = shifted;
                            valid_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else if (cnt_q == MAX_CNT) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = SYNC;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SYNC;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            error_q     <= error_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_end = frame_end_q;
    assign error     = error_q;

`ifdef UNIPOLAR_RZ_RX_FORWARD_EN
    logic fwd_q, fwd_d;
    logic line_out_q, line_out_d;

    // Forwarding opens once the first word of a frame has been consumed and
    // closes at the frame gap, so each receiver strips exactly one word.
    always_comb begin
        fwd_d = fwd_q;
        if (frame_end_d) begin
            fwd_d = 1'b0;
        end else if (valid_d) begin
            fwd_d = 1'b1;
        end
        line_out_d = fwd_q && !frame_end_d && ls;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_q      <= 1'b0;
            line_out_q <= 1'b0;
        end else begin
            fwd_q      <= fwd_d;
            line_out_q <= line_out_d;
        end
    end

    assign line_out = line_out_q;
`else
    assign line_out = 1'b0;
`endif

endmodule

// File: tb/tb_unipolar_rz_rx.sv
// tb_unipolar_rz_rx
// Directed bench for unipolar_rz_rx at default parameters. Expected words are
// queued as they are transmitted and compared when valid pulses; pulse counts
// and timing of valid/error/frame_end are checked after each step.
module tb_unipolar_rz_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        line;
    logic [23:0] data;
    logic        valid;
    logic        frame_end;
    logic        error;
    logic        line_out;

`ifdef UNIPOLAR_RZ_RX_FORWARD_EN
    localparam int FWD_RISES = 96;
`else
    localparam int FWD_RISES = 0;
`endif

    int check_count     = 0;
    int pass_count      = 0;
    int fail_count      = 0;
    int cycle           = 0;
    int valid_count     = 0;
    int error_count     = 0;
    int frame_end_count = 0;
    int lo_rise_count   = 0;
    int valid_cycle     = 0;
    int error_cycle     = 0;
    int frame_end_cycle = 0;
    int last_fall_cycle = 0;
    logic line_out_prev = 1'b0;
    logic [23:0] exp_q[$];

    unipolar_rz_rx dut (
        .clock     (clock),
        .reset     (reset),
        .line      (line),
        .data      (data),
        .valid     (valid),
        .frame_end (frame_end),
        .error     (error),
        .line_out  (line_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one pulse: high for high_cycles, then low for low_cycles.
    // Starts and ends on a falling clock edge.
    task automatic applyStimulus(input int high_cycles, input int low_cycles);
        line = 1'b1;
        repeat (high_cycles) @(negedge clock);
        line = 1'b0;
        last_fall_cycle = cycle;
        repeat (low_cycles) @(negedge clock);
    endtask

    task automatic sendBits(input logic [23:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (word[i]) applyStimulus(60, 60);
            else         applyStimulus(30, 90);
        end
    endtask

    task automatic sendWord(input logic [23:0] word, input bit expect_it);
        if (expect_it) exp_q.push_back(word);
        sendBits(word, 24);
    endtask

    task automatic holdLow(input int n);
        line = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Scoreboard side: every valid pops the oldest queued word; pulses are
    // tallied for the step checks in the main sequence.
    always @(negedge clock) begin
        if (valid) begin
            valid_count++;
            valid_cycle = cycle;
            checkOutput("valid_with_error", {31'd0, error}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("data_word", {8'd0, data}, {8'd0, exp_q.pop_front()});
            end
        end
        if (error) begin
            error_count++;
            error_cycle = cycle;
        end
        if (frame_end) begin
            frame_end_count++;
            frame_end_cycle = cycle;
        end
        if (line_out && !line_out_prev) lo_rise_count++;
        line_out_prev = line_out;
    end

    initial begin
        int v0, e0, f0, diff;
        logic [23:0] sweep;

        reset = 1'b1;
        line  = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("reset_data",      {8'd0, data},          32'd0);
        checkOutput("reset_valid",     {31'd0, valid},        32'd0);
        checkOutput("reset_frame_end", {31'd0, frame_end},    32'd0);
        checkOutput("reset_error",     {31'd0, error},        32'd0);
        checkOutput("reset_line_out",  {31'd0, line_out},     32'd0);
        reset = 1'b0;

        // Alignment gap, then one word; the SYNC exit must be silent.
        $display("[TB] step 1: single word after power-up gap");
        holdLow(5100);
        lo_rise_count = 0;
        sendWord(24'habcdef, 1'b1);
        checkOutput("w1_valid_count",   valid_count,     1);
        checkOutput("w1_error_count",   error_count,     0);
        checkOutput("w1_frame_end_cnt", frame_end_count, 0);
        checkOutput("w1_latency",       valid_cycle - last_fall_cycle, 3);

        $display("[TB] step 2: four back-to-back words then gap");
        for (int i = 0; i < 4; i++) sendWord(24'habcdef + 24'(i + 1), 1'b1);
        holdLow(8000);
        checkOutput("w4_valid_count",   valid_count,     5);
        checkOutput("w4_error_count",   error_count,     0);
        checkOutput("w4_frame_end_cnt", frame_end_count, 1);
        diff = frame_end_cycle - last_fall_cycle;
        checkOutput("frame_end_delay", (diff >= 4997 && diff <= 5003) ? 5000 : diff, 5000);
        checkOutput("fwd_rises",        lo_rise_count,   FWD_RISES);
        checkOutput("queue_drained_2",  exp_q.size(),    0);

        $display("[TB] step 3: glitch mid-word");
        v0 = valid_count; e0 = error_count; f0 = frame_end_count;
        sendBits(24'h00ff00, 8);
        applyStimulus(5, 115);
        sendWord(24'h555555, 1'b0);
        checkOutput("glitch_error",    error_count, e0 + 1);
        checkOutput("glitch_no_valid", valid_count, v0);
        holdLow(5100);
        checkOutput("resync_silent",   frame_end_count, f0);

        $display("[TB] step 4: partial word then gap");
        e0 = error_count; f0 = frame_end_count;
        sendBits(24'h3c3c3c, 10);
        holdLow(5100);
        checkOutput("partial_frame_end", frame_end_count, f0 + 1);
        checkOutput("partial_error",     error_count,     e0 + 1);
        checkOutput("partial_same_cyc",  error_cycle,     frame_end_cycle);
        checkOutput("partial_no_valid",  valid_count,     v0);

        // Bits 0,1,3,4 of 24'h123456 are 0,1,0,1, sent at 44, 45, 10 and
        // 100 cycles high respectively.
        $display("[TB] step 5: pulse-width boundaries");
        v0 = valid_count; e0 = error_count;
        sweep = 24'h123456;
        exp_q.push_back(sweep);
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       applyStimulus(44, 76);
                1:       applyStimulus(45, 75);
                3:       applyStimulus(10, 110);
                4:       applyStimulus(100, 20);
                default: sendBits(sweep >> i, 1);
            endcase
        end
        checkOutput("sweep_valid", valid_count, v0 + 1);
        checkOutput("sweep_error", error_count, e0);
        applyStimulus(101, 50);
        checkOutput("too_long_error",    error_count, e0 + 1);
        checkOutput("too_long_no_valid", valid_count, v0 + 1);
        holdLow(5100);

        $display("[TB] step 6: reset mid-frame");
        sendBits(24'hfedcba, 12);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("midreset_data",  {8'd0, data},   32'd0);
        checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
        reset = 1'b0;
        v0 = valid_count;
        sendWord(24'h0f1e2d, 1'b0);
        checkOutput("postreset_no_valid", valid_count, v0);
        holdLow(5100);
        sendWord(24'h0f1e2d, 1'b1);
        holdLow(10);
        checkOutput("postreset_valid", valid_count, v0 + 1);
        checkOutput("queue_drained",   exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
